// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the MIPS pipeline execution sequencer:
//   - state encoding of the sequencer FSM (IDLE, RUN, STEP, DRAIN, HALTED)
//   - debug-unit command codes (CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP)
//   - default number of drain cycles issued after a HALT is decoded
//   - width of the drain counter (enough for drain lengths up to 15)
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t RUN    = 3'd1;
    localparam state_t STEP   = 3'd2;
    localparam state_t DRAIN  = 3'd3;
    localparam state_t HALTED = 3'd4;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam int DEFAULT_DRAIN_CYCLES = 4;
    localparam int DRAIN_CNT_W          = 4;

endpackage

// File: rtl/pipeline_step_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Free-running up counter with enable that sticks at all-ones instead of
// wrapping. Used to count the cycles in which the pipeline actually advanced.
//
// Ports:
//   clk      in   clock, rising edge
//   i_reset  in   synchronous active-high clear
//   i_en     in   count enable, one increment per enabled edge
//   o_count  out  [NB_DATA-1:0] current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_en,
    output logic [NB_DATA-1:0] o_count
);

    logic [NB_DATA-1:0] count_q;

    // Counter register: cleared by reset, otherwise advances when enabled and
    // holds once every bit is set so a long run never rolls back to zero.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_en && (count_q != {NB_DATA{1'b1}})) begin
            count_q <= count_q + NB_DATA'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_step_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_step_ctrl
// Execution sequencer for the five-stage MIPS pipeline. Produces the common
// step enable that advances all pipeline registers, takes RUN / STEP / STOP
// commands from the debug unit over a valid/ready handshake, drains the
// pipeline automatically once a HALT is decoded in ID and then freezes.
//
// Optional feature: define PIPELINE_STEP_CTRL_CYCLE_CNT_EN to build the
// saturating executed-cycle counter; without it o_cycle_count is tied to 0.
//
// Ports:
//   clk            in   clock, rising edge
//   i_reset        in   synchronous active-high reset
//   i_cmd_valid    in   command present
//   i_cmd          in   [1:0] 00 NOP, 01 RUN, 10 STEP, 11 STOP
//   o_cmd_ready    out  command can be accepted this cycle
//   i_halt         in   HALT decoded in ID (only looked at while stepping)
//   o_step         out  registered pipeline advance enable
//   o_running      out  sequencer is in RUN
//   o_halted       out  sequencer is in HALTED
//   o_done         out  one-cycle pulse when a STEP finishes or HALTED is entered
//   o_cycle_count  out  [NB_DATA-1:0] number of cycles with o_step high
// ----------------------------------------------------------------------------
module pipeline_step_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_halt,
    output logic               o_step,
    output logic               o_running,
    output logic               o_halted,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_cycle_count
);

    state_t                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drainCnt_q, drainCnt_d;
    logic                   step_q, step_d;
    logic                   running_q, running_d;
    logic                   halted_q, halted_d;
    logic                   done_q, done_d;
    logic                   cmdReady;
    logic                   cmdAccept;
    logic                   haltSeen;

    // The debug unit may talk to us whenever we are not in the middle of a
    // single step or a drain; a command counts only when both sides agree.
    // A HALT decode is only trusted while the pipeline is actually advancing,
    // otherwise ID holds a stale instruction.
    assign cmdReady  = (state_q == IDLE) || (state_q == RUN) || (state_q == HALTED);
    assign cmdAccept = i_cmd_valid && cmdReady;
    assign haltSeen  = i_halt && step_q;

    // State register: holds the FSM state, the drain countdown and the
    // registered versions of every status output so none of them glitch.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
            step_q     <= 1'b0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            step_q     <= step_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. A detected HALT beats any command arriving in the
    // same cycle, so STOP together with HALT still drains the pipeline. The
    // drain ends on the edge where the countdown sits at 1, which yields
    // exactly DRAIN_CYCLES stepping cycles after the HALT edge.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    if (i_cmd == CMD_RUN) begin
                        state_d = RUN;
                    end else if (i_cmd == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
            end
            RUN: begin
                if (haltSeen) begin
                    state_d    = DRAIN;
                    drainCnt_d = DRAIN_CNT_W'(DRAIN_CYCLES);
                end else if (cmdAccept && (i_cmd == CMD_STOP)) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (haltSeen) begin
                    state_d    = DRAIN;
                    drainCnt_d = DRAIN_CNT_W'(DRAIN_CYCLES);
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q - DRAIN_CNT_W'(1);
                if (drainCnt_q == DRAIN_CNT_W'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: derive the next registered outputs from the state we are
    // about to enter, and flag done on the two completion transitions.
    always_comb begin
        step_d    = (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN);
        running_d = (state_d == RUN);
        halted_d  = (state_d == HALTED);
        done_d    = ((state_q == STEP)  && (state_d == IDLE)) ||
                    ((state_q == DRAIN) && (state_d == HALTED));
    end

    assign o_cmd_ready = cmdReady;
    assign o_step      = step_q;
    assign o_running   = running_q;
    assign o_halted    = halted_q;
    assign o_done      = done_q;

`ifdef PIPELINE_STEP_CTRL_CYCLE_CNT_EN
    // Executed-cycle counter: one tick per cycle the pipeline advanced.
    sat_counter #(
        .NB_DATA (NB_DATA)
    ) u_cycle_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .i_en    (step_q),
        .o_count (o_cycle_count)
    );
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_step_ctrl
// Self-checking bench for pipeline_step_ctrl: a table of single-cycle vectors
// covering reset, single steps and ignored commands, followed by hand-written
// sequences for RUN/STOP, HALT drain, STEP+HALT, STOP+HALT and reset mid-drain.
// Expected cycle counts are zero when PIPELINE_STEP_CTRL_CYCLE_CNT_EN is off.
// ----------------------------------------------------------------------------
module tb_pipeline_step_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        cmdValid;
    logic [1:0]  cmd;
    logic        cmdReady;
    logic        halt;
    logic        step;
    logic        running;
    logic        halted;
    logic        done;
    logic [31:0] cycleCount;

    int checkCount;
    int passCount;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [1:0]  cmd;
        logic        halt;
        logic        eStep;
        logic        eRun;
        logic        eHalt;
        logic        eDone;
        logic        eRdy;
        logic [31:0] eCnt;
    } vec_t;

    vec_t vecs [11];

    pipeline_step_ctrl #(
        .NB_DATA      (32),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk           (clock),
        .i_reset       (reset),
        .i_cmd_valid   (cmdValid),
        .i_cmd         (cmd),
        .o_cmd_ready   (cmdReady),
        .i_halt        (halt),
        .o_step        (step),
        .o_running     (running),
        .o_halted      (halted),
        .o_done        (done),
        .o_cycle_count (cycleCount)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net in case the run ever stops making progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected counter value depending on whether the counter is built.
    function automatic logic [31:0] expCnt(input int n);
`ifdef PIPELINE_STEP_CTRL_CYCLE_CNT_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic vec_t mkVec(input logic r, input logic v, input logic [1:0] c,
                                   input logic h, input logic s, input logic ru,
                                   input logic ha, input logic d, input logic rd,
                                   input int n);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.cmd   = c;
        t.halt  = h;
        t.eStep = s;
        t.eRun  = ru;
        t.eHalt = ha;
        t.eDone = d;
        t.eRdy  = rd;
        t.eCnt  = 32'(n);
        return t;
    endfunction

    // Drive one cycle of inputs, let the DUT see them at the rising edge and
    // return 1 time unit later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] c,
                                 input logic h);
        reset    = r;
        cmdValid = v;
        cmd      = c;
        halt     = h;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic s, input logic ru,
                               input logic ha, input logic d, input logic rd,
                               input logic [31:0] n);
        checkCount++;
        if ({step, running, halted, done, cmdReady, cycleCount} !== {s, ru, ha, d, rd, n}) begin
            $display("[TB] FAIL %s: got step=%b run=%b halted=%b done=%b ready=%b cnt=%0d, want step=%b run=%b halted=%b done=%b ready=%b cnt=%0d",
                     name, step, running, halted, done, cmdReady, cycleCount,
                     s, ru, ha, d, rd, n);
        end else begin
            passCount++;
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        cmdValid   = 1'b0;
        cmd        = CMD_NOP;
        halt       = 1'b0;

        // Table: reset, halt ignored while idle, three single steps, STOP in
        // IDLE ignored, RUN offered during STEP not accepted.
        vecs[0]  = mkVec(1, 0, CMD_NOP,  0,  0, 0, 0, 0, 1, 0);
        vecs[1]  = mkVec(0, 0, CMD_NOP,  1,  0, 0, 0, 0, 1, 0);
        vecs[2]  = mkVec(0, 1, CMD_STEP, 0,  1, 0, 0, 0, 0, 0);
        vecs[3]  = mkVec(0, 0, CMD_NOP,  0,  0, 0, 0, 1, 1, 1);
        vecs[4]  = mkVec(0, 1, CMD_STOP, 0,  0, 0, 0, 0, 1, 1);
        vecs[5]  = mkVec(0, 1, CMD_STEP, 0,  1, 0, 0, 0, 0, 1);
        vecs[6]  = mkVec(0, 0, CMD_NOP,  0,  0, 0, 0, 1, 1, 2);
        vecs[7]  = mkVec(0, 0, CMD_NOP,  0,  0, 0, 0, 0, 1, 2);
        vecs[8]  = mkVec(0, 1, CMD_STEP, 0,  1, 0, 0, 0, 0, 2);
        vecs[9]  = mkVec(0, 1, CMD_RUN,  0,  0, 0, 0, 1, 1, 3);
        vecs[10] = mkVec(0, 0, CMD_NOP,  0,  0, 0, 0, 0, 1, 3);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].cmd, vecs[i].halt);
            checkOutput($sformatf("vec%0d", i), vecs[i].eStep, vecs[i].eRun,
                        vecs[i].eHalt, vecs[i].eDone, vecs[i].eRdy, expCnt(int'(vecs[i].eCnt)));
        end

        // RUN for ten step cycles with extra RUN/STEP commands ignored, then STOP.
        applyStimulus(1, 0, CMD_NOP, 0);
        checkOutput("run_reset", 0, 0, 0, 0, 1, expCnt(0));
        applyStimulus(0, 1, CMD_RUN, 0);
        checkOutput("run_start", 1, 1, 0, 0, 1, expCnt(0));
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, (i == 4) || (i == 7), (i == 4) ? CMD_RUN : CMD_STEP, 0);
            checkOutput($sformatf("run_hold%0d", i), 1, 1, 0, 0, 1, expCnt(i));
        end
        applyStimulus(0, 1, CMD_STOP, 0);
        checkOutput("run_stop", 0, 0, 0, 0, 1, expCnt(10));
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("run_after_stop", 0, 0, 0, 0, 1, expCnt(10));

        // RUN, HALT on the 6th step cycle, four drain cycles, then frozen.
        applyStimulus(1, 0, CMD_NOP, 0);
        applyStimulus(0, 1, CMD_RUN, 0);
        checkOutput("halt_run", 1, 1, 0, 0, 1, expCnt(0));
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, CMD_NOP, 0);
            checkOutput($sformatf("halt_pre%0d", i), 1, 1, 0, 0, 1, expCnt(i));
        end
        applyStimulus(0, 0, CMD_NOP, 1);
        checkOutput("halt_enter", 1, 0, 0, 0, 0, expCnt(6));
        for (int i = 7; i <= 9; i++) begin
            applyStimulus(0, 0, CMD_NOP, 0);
            checkOutput($sformatf("halt_drain%0d", i), 1, 0, 0, 0, 0, expCnt(i));
        end
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("halt_done", 0, 0, 1, 1, 1, expCnt(10));
        applyStimulus(0, 1, CMD_RUN, 0);
        checkOutput("halted_run", 0, 0, 1, 0, 1, expCnt(10));
        applyStimulus(0, 1, CMD_STEP, 0);
        checkOutput("halted_step", 0, 0, 1, 0, 1, expCnt(10));
        applyStimulus(0, 0, CMD_NOP, 1);
        checkOutput("halted_hold", 0, 0, 1, 0, 1, expCnt(10));

        // STEP with HALT in the step cycle; ready stays low across the drain.
        applyStimulus(1, 0, CMD_NOP, 0);
        applyStimulus(0, 1, CMD_STEP, 0);
        checkOutput("stephalt_step", 1, 0, 0, 0, 0, expCnt(0));
        applyStimulus(0, 0, CMD_NOP, 1);
        checkOutput("stephalt_enter", 1, 0, 0, 0, 0, expCnt(1));
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(0, 1, CMD_RUN, 0);
            checkOutput($sformatf("stephalt_drain%0d", i), 1, 0, 0, 0, 0, expCnt(i));
        end
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("stephalt_done", 0, 0, 1, 1, 1, expCnt(5));
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("stephalt_after", 0, 0, 1, 0, 1, expCnt(5));

        // STOP and HALT in the same RUN cycle: the drain takes priority.
        applyStimulus(1, 0, CMD_NOP, 0);
        applyStimulus(0, 1, CMD_RUN, 0);
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("stophalt_run", 1, 1, 0, 0, 1, expCnt(1));
        applyStimulus(0, 1, CMD_STOP, 1);
        checkOutput("stophalt_enter", 1, 0, 0, 0, 0, expCnt(2));
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(0, 0, CMD_NOP, 0);
            checkOutput($sformatf("stophalt_drain%0d", i), 1, 0, 0, 0, 0, expCnt(i));
        end
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("stophalt_done", 0, 0, 1, 1, 1, expCnt(6));

        // Reset on the second drain cycle, then a normal STEP.
        applyStimulus(1, 0, CMD_NOP, 0);
        applyStimulus(0, 1, CMD_RUN, 0);
        applyStimulus(0, 0, CMD_NOP, 1);
        checkOutput("rstdrain_enter", 1, 0, 0, 0, 0, expCnt(1));
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("rstdrain_second", 1, 0, 0, 0, 0, expCnt(2));
        applyStimulus(1, 0, CMD_NOP, 0);
        checkOutput("rstdrain_reset", 0, 0, 0, 0, 1, expCnt(0));
        applyStimulus(0, 1, CMD_STEP, 0);
        checkOutput("rstdrain_step", 1, 0, 0, 0, 0, expCnt(0));
        applyStimulus(0, 0, CMD_NOP, 0);
        checkOutput("rstdrain_done", 0, 0, 0, 1, 1, expCnt(1));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
